// File: rtl/pio_pkg.sv
// Shared definitions for the pio control-port command bridge: action codes,
// header layout and the parser state encoding.
package pio_pkg;

  localparam logic [3:0] ACT_INSTR   = 4'd1;
  localparam logic [3:0] ACT_PEND    = 4'd2;
  localparam logic [3:0] ACT_PULL    = 4'd3;
  localparam logic [3:0] ACT_PUSH    = 4'd4;
  localparam logic [3:0] ACT_PINS    = 4'd5;
  localparam logic [3:0] ACT_EN      = 4'd6;
  localparam logic [3:0] ACT_DIV     = 4'd7;
  localparam logic [3:0] ACT_SIDESET = 4'd8;
  localparam logic [3:0] ACT_IMM     = 4'd9;

  localparam int HDR_MARKER = 7;

  typedef enum logic [2:0] {
    ST_HDR, ST_IDX, ST_DAT, ST_ISSUE, ST_WAIT, ST_RESP
  } bridge_state_e;

  function automatic logic is_valid_action(input logic [3:0] a);
    return (a != 4'd0) && (a <= ACT_IMM);
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    return w[8*i +: 8];
  endfunction

endpackage

// File: rtl/pio_cmd_bridge.sv
// Host byte-stream to pio control-port bridge: parses 6-byte command packets
// into single-cycle strobes and returns dout as 4 bytes after pull commands.
module pio_cmd_bridge
  import pio_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RESP_DELAY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [3:0]  action,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  output logic [31:0] din,
  input  logic [31:0] dout
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DW = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(RESP_DELAY - 1);

  bridge_state_e state;
  logic [1:0]    cnt;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] wcnt;
  logic [3:0]    act_sh;
  logic [1:0]    mindex_sh;
  logic [4:0]    index_sh;
  logic [23:0]   din_sh;
  logic [31:0]   resp;
  logic          rx_xfer;
  logic          timeout;

  assign rx_xfer = rx_valid & rx_ready;
  assign timeout = (tcnt == T_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_HDR;
      cnt       <= '0;
      tcnt      <= '0;
      wcnt      <= '0;
      act_sh    <= '0;
      mindex_sh <= '0;
      index_sh  <= '0;
      din_sh    <= '0;
      resp      <= '0;
      rx_ready  <= 1'b0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      action    <= '0;
      index     <= '0;
      mindex    <= '0;
      din       <= '0;
    end else begin
      action <= '0;
      if (rx_xfer || state == ST_HDR)
        tcnt <= '0;
      else if (state == ST_IDX || state == ST_DAT)
        tcnt <= tcnt + 1'b1;

      case (state)
        ST_HDR: begin
          rx_ready <= 1'b1;
          if (rx_xfer && rx_data[HDR_MARKER] && is_valid_action(rx_data[3:0])) begin
            act_sh    <= rx_data[3:0];
            mindex_sh <= rx_data[5:4];
            state     <= ST_IDX;
          end
        end
        ST_IDX: begin
          if (rx_xfer) begin
            index_sh <= rx_data[4:0];
            cnt      <= '0;
            state    <= ST_DAT;
          end else if (timeout) begin
            state <= ST_HDR;
          end
        end
        ST_DAT: begin
          if (rx_xfer) begin
            cnt <= cnt + 2'd1;
            case (cnt)
              2'd0: din_sh[7:0]   <= rx_data;
              2'd1: din_sh[15:8]  <= rx_data;
              2'd2: din_sh[23:16] <= rx_data;
              default: begin
                // strobe lands in the ISSUE cycle, so load outputs on entry
                action   <= act_sh;
                index    <= index_sh;
                mindex   <= mindex_sh;
                din      <= {rx_data, din_sh};
                rx_ready <= 1'b0;
                state    <= ST_ISSUE;
              end
            endcase
          end else if (timeout) begin
            state <= ST_HDR;
          end
        end
        ST_ISSUE: begin
          wcnt <= '0;
          if (act_sh == ACT_PULL) begin
            state <= ST_WAIT;
          end else begin
            rx_ready <= 1'b1;
            state    <= ST_HDR;
          end
        end
        ST_WAIT: begin
          if (wcnt == D_LAST) begin
            resp     <= dout;
            tx_data  <= dout[7:0];
            tx_valid <= 1'b1;
            cnt      <= '0;
            state    <= ST_RESP;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (tx_ready) begin
            if (cnt == 2'd3) begin
              tx_valid <= 1'b0;
              rx_ready <= 1'b1;
              state    <= ST_HDR;
            end else begin
              cnt     <= cnt + 2'd1;
              tx_data <= byte_of(resp, cnt + 2'd1);
            end
          end
        end
        default: state <= ST_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_cmd_bridge.sv
// Directed bench for pio_cmd_bridge: packet decode, pull response, header
// filtering, timeout resync, tx back-pressure and mid-packet reset.
module tb_pio_cmd_bridge;
  localparam int TO = 20;
  localparam int RD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;
  logic [31:0] dout;

  pio_cmd_bridge #(.TIMEOUT_CYCLES(TO), .RESP_DELAY(RD)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .action(action), .index(index), .mindex(mindex), .din(din), .dout(dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // monitor state, sampled on the falling edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          stb_n = 0;
  int          stb_cyc = 0;
  logic [3:0]  stb_act;
  logic [4:0]  stb_idx;
  logic [1:0]  stb_mi;
  logic [31:0] stb_din;
  logic [7:0]  tx_q[$];
  int          tv_cycles = 0;
  int          tx_first_cyc = 0;
  logic        prev_tv = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_td = '0;
  int          stall_bad = 0;
  logic        pend = 1'b0;
  int          rx_busy_viol = 0;
  int          acc_cyc = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (action != 4'd0) begin
        stb_n++;
        stb_cyc = cyc;
        stb_act = action; stb_idx = index; stb_mi = mindex; stb_din = din;
        if (action == 4'd3) pend = 1'b1;
      end
      if (pend && rx_ready) rx_busy_viol++;
      if (tx_valid) tv_cycles++;
      if (tx_valid && !prev_tv) tx_first_cyc = cyc;
      if (prev_stall && tx_data != prev_td) stall_bad++;
      prev_stall = tx_valid && !tx_ready;
      prev_td = tx_data;
      prev_tv = tx_valid;
      if (tx_valid && tx_ready) begin
        tx_q.push_back(tx_data);
        if (tx_q.size() == 4) pend = 1'b0;
      end
    end else begin
      prev_tv = 1'b0; prev_stall = 1'b0; pend = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 200) begin @(negedge clk); n++; end
    if (!rx_ready) chk("rx_accept_timeout", {31'd0, rx_ready}, 32'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, b1, b2, b3, b4, b5);
    send_byte(b0); send_byte(b1); send_byte(b2);
    send_byte(b3); send_byte(b4); send_byte(b5);
  endtask

  task automatic wait_tx4();
    int n = 0;
    while (tx_q.size() < 4 && n < 200) begin tick(1); n++; end
    chk("tx_count", tx_q.size(), 32'd4);
  endtask

  function automatic logic [31:0] txw();
    logic [31:0] w = 32'hFFFF_FFFF;
    if (tx_q.size() >= 4) w = {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
    return w;
  endfunction

  int n0;

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0; dout = '0;
    tick(3);
    chk("rst_rx_ready", {31'd0, rx_ready}, 0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    chk("rst_outs", {action, index, mindex, 21'd0}, 0);
    chk("rst_din", din, 0);
    reset = 1'b0;

    // plain instruction write
    n0 = stb_n; tx_q.delete(); tv_cycles = 0;
    send_pkt(8'h81, 8'h03, 8'h34, 8'h12, 8'h00, 8'h00);
    tick(5);
    chk("t1_strobes", stb_n - n0, 1);
    chk("t1_latency", stb_cyc - acc_cyc, 1);
    chk("t1_fields", {stb_act, stb_mi, stb_idx}, {4'd1, 2'd0, 5'd3});
    chk("t1_din", stb_din, 32'h0000_1234);
    chk("t1_action_clear", {28'd0, action}, 0);
    chk("t1_hold", {index, din[15:0]}, {5'd3, 16'h1234});
    chk("t1_no_tx", tv_cycles, 0);

    // pull with response
    n0 = stb_n; tx_q.delete(); rx_busy_viol = 0;
    dout = 32'hDEAD_BEEF; tx_ready = 1'b1;
    send_pkt(8'h93, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_tx4();
    tick(2);
    chk("t2_strobes", stb_n - n0, 1);
    chk("t2_fields", {stb_act, stb_mi}, {4'd3, 2'd1});
    chk("t2_resp_delay", tx_first_cyc - stb_cyc, RD + 1);
    chk("t2_bytes", txw(), 32'hDEAD_BEEF);
    chk("t2_rx_blocked", rx_busy_viol, 0);
    chk("t2_rx_ready_back", {31'd0, rx_ready}, 1);
    chk("t2_tx_idle", {31'd0, tx_valid}, 0);

    // bad headers are discarded
    n0 = stb_n;
    send_byte(8'h05); send_byte(8'h8A); send_byte(8'h80);
    send_pkt(8'h87, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00);
    tick(3);
    chk("t3_strobes", stb_n - n0, 1);
    chk("t3_action", {28'd0, stb_act}, 7);
    chk("t3_din", stb_din, 32'h5);

    // idle just under the timeout keeps the packet alive
    n0 = stb_n;
    send_byte(8'h86); send_byte(8'h00);
    tick(TO - 5);
    send_byte(8'h0F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    tick(3);
    chk("t4a_strobes", stb_n - n0, 1);
    chk("t4a_din", stb_din, 32'hF);

    // full timeout drops the partial packet
    n0 = stb_n;
    send_byte(8'h86); send_byte(8'h00);
    tick(TO + 5);
    chk("t4b_no_strobe", stb_n - n0, 0);
    send_pkt(8'h86, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00);
    tick(3);
    chk("t4b_strobes", stb_n - n0, 1);
    chk("t4b_action", {28'd0, stb_act}, 6);
    chk("t4b_din", stb_din, 32'hF);

    // tx back-pressure: ready 1,0,0,1
    tx_q.delete(); stall_bad = 0;
    dout = 32'h4433_2211; tx_ready = 1'b1;
    send_pkt(8'hA3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    n0 = 0;
    @(negedge clk);
    while (!tx_valid && n0 < 50) begin @(negedge clk); n0++; end
    chk("t5_tx_start", {31'd0, tx_valid}, 1);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    tick(2);
    tx_ready = 1'b1;
    wait_tx4();
    tick(2);
    chk("t5_bytes", txw(), 32'h4433_2211);
    chk("t5_stall_stable", stall_bad, 0);
    chk("t5_mindex", {30'd0, stb_mi}, 2);

    // reset mid-packet
    send_byte(8'h81); send_byte(8'h05); send_byte(8'hAA);
    reset = 1'b1;
    tick(2);
    chk("t6_rst_outs", {action, index, mindex, 21'd0}, 0);
    chk("t6_rst_din", din, 0);
    chk("t6_rst_rdy", {30'd0, rx_ready, tx_valid}, 0);
    reset = 1'b0;
    n0 = stb_n;
    send_pkt(8'h82, 8'h07, 8'h78, 8'h56, 8'h34, 8'h12);
    tick(3);
    chk("t6_strobes", stb_n - n0, 1);
    chk("t6_fields", {stb_act, stb_mi, stb_idx}, {4'd2, 2'd0, 5'd7});
    chk("t6_din", stb_din, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
